// File: rtl/dmem_responder_if.sv
// Core load/store port: byte address, store data/strobe, load strobe and registered load data.
interface dmem_responder_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] read_data;

  modport master (output address, write_data, write_enable, read_enable, input read_data);
  modport slave  (input address, write_data, write_enable, read_enable, output read_data);
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window (STATUS, PIXEL FIFO pop, LED).
// Loads have one cycle of latency. Bad accesses set a sticky fault flag.
module dmem_responder #(
  parameter int          DEPTH      = 256,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_responder_if.slave      bus,
  input  logic                 pix_valid,
  input  logic [7:0]           pix_data,
  output logic                 pix_ready,
  output logic [7:0]           led,
  output logic                 fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   ram [DEPTH];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          aligned, in_ram, is_status, is_pixel, is_led, mapped, bad;
  logic          store, load, push, pop;
  logic [AW-1:0] widx;
  logic [31:0]   status_word, rdata_next;

  always_comb begin
    full      = (count == CW'(FIFO_DEPTH));
    empty     = (count == '0);
    pix_ready = ~full;
    aligned   = (bus.address[1:0] == 2'b00);
    in_ram    = (bus.address[31:AW+2] == '0);
    is_status = (bus.address == MMIO_BASE);
    is_pixel  = (bus.address == MMIO_BASE + 32'd4);
    is_led    = (bus.address == MMIO_BASE + 32'd8);
    mapped    = aligned & (in_ram | is_status | is_pixel | is_led);
    // Store and load on the same cycle is treated as a bad access.
    bad       = (bus.write_enable | bus.read_enable) &
                (~mapped | (bus.write_enable & bus.read_enable));
    store     = bus.write_enable & ~bad;
    load      = bus.read_enable & ~bad;
    widx      = bus.address[AW+1:2];
    push      = pix_valid & ~full;
    pop       = load & is_pixel & ~empty;
    status_word = {fault, 21'b0, full, empty, 2'b00, 6'(count)};
  end

  always_comb begin
    rdata_next = '0;
    if (!bad) begin
      if (in_ram)         rdata_next = ram[widx];
      else if (is_status) rdata_next = status_word;
      else if (is_pixel)  rdata_next = empty ? 32'd0 : {24'b0, fifo[rd_ptr]};
      else if (is_led)    rdata_next = {24'b0, led};
    end
  end

  // Storage arrays carry no reset; only the control state below is cleared.
  always_ff @(posedge clk) begin
    if (store && in_ram) ram[widx] <= bus.write_data;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= pix_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.read_data <= '0;
      led           <= '0;
      fault         <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      if (bus.read_enable) bus.read_data <= rdata_next;
      if (store && is_led) led <= bus.write_data[7:0];
      if (bad)                    fault <= 1'b1;
      else if (store && is_status) fault <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: queue/array reference model, per-cycle compare, directed and random stimulus.
module tb_dmem_responder;
  localparam int          DEPTH = 256;
  localparam int          FD    = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] ST    = BASE;
  localparam logic [31:0] PX    = BASE + 32'd4;
  localparam logic [31:0] LD    = BASE + 32'd8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_ready;
  logic [7:0] led;
  logic       fault;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH(DEPTH), .FIFO_DEPTH(FD), .MMIO_BASE(BASE)) dut (
    .clk(clk), .reset(rst_n), .bus(bus.slave),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .led(led), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] m_ram [DEPTH];
  bit          m_known [DEPTH];
  logic [7:0]  q [$];
  logic [7:0]  m_led;
  logic        m_fault;
  logic [31:0] m_rd;
  bit          m_rd_known;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_led = '0; m_fault = 1'b0; m_rd = '0; m_rd_known = 1'b1;
  endfunction

  // Behavioural model of one clock edge from the inputs present before it.
  function automatic void model_step(input logic [31:0] a, input logic [31:0] wd,
                                     input logic we, input logic re,
                                     input logic pv, input logic [7:0] pd);
    bit al, r, s, p, l, bad, full, emp;
    int idx;
    al   = (a[1:0] == 2'b00);
    r    = (a < DEPTH * 4);
    s    = (a == ST); p = (a == PX); l = (a == LD);
    bad  = (we || re) && (!(al && (r || s || p || l)) || (we && re));
    full = (q.size() == FD);
    emp  = (q.size() == 0);
    idx  = int'(a >> 2) % DEPTH;
    if (re) begin
      m_rd_known = 1'b1;
      if (bad) m_rd = '0;
      else if (r) begin m_rd = m_ram[idx]; m_rd_known = m_known[idx]; end
      else if (s) m_rd = {m_fault, 21'b0, full, emp, 2'b00, 6'(q.size())};
      else if (p) m_rd = emp ? 32'd0 : {24'b0, q.pop_front()};
      else        m_rd = {24'b0, m_led};
    end
    if (we && !bad) begin
      if (r) begin m_ram[idx] = wd; m_known[idx] = 1'b1; end
      else if (l) m_led = wd[7:0];
      else if (s) m_fault = 1'b0;
    end
    if (bad) m_fault = 1'b1;
    if (pv && !full) q.push_back(pd);
  endfunction

  task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic we,
                    input logic re, input logic pv, input logic [7:0] pd);
    bus.address = a; bus.write_data = wd; bus.write_enable = we; bus.read_enable = re;
    pix_valid = pv; pix_data = pd;
    @(posedge clk);
    model_step(a, wd, we, re, pv, pd);
    #1;
  endtask

  task automatic idle();
    op(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic lit_rd(input string nm, input logic [31:0] exp);
    @(negedge clk);
    chk({nm, " dut"}, bus.read_data, exp);
    chk({nm, " model"}, m_rd, exp);
  endtask

  task automatic load(input logic [31:0] a, input string nm, input logic [31:0] exp);
    op(a, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    lit_rd(nm, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd);
    op(a, wd, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (m_rd_known) chk("read_data", bus.read_data, m_rd);
        chk("led", {24'b0, led}, {24'b0, m_led});
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        chk("pix_ready", {31'b0, pix_ready}, {31'b0, q.size() < FD});
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic we, re;
    int k;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    bus.address = '0; bus.write_data = '0; bus.write_enable = 1'b0; bus.read_enable = 1'b0;

    // Power-on reset
    #2 rst_n = 1'b0;
    model_reset();
    chk_en = 1'b1;
    #1;
    chk("reset read_data", bus.read_data, 32'd0);
    chk("reset led", {24'b0, led}, 32'd0);
    chk("reset fault", {31'b0, fault}, 32'd0);
    chk("reset pix_ready", {31'b0, pix_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // RAM store/load
    store(32'h10, 32'hDEADBEEF);
    load(32'h10, "ram 0x10", 32'hDEADBEEF);

    // Fill FIFO to full
    for (int i = 1; i <= 16; i++) op(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'(i));
    @(negedge clk);
    chk("full pix_ready", {31'b0, pix_ready}, 32'd0);
    op(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h11);
    load(ST, "status full", 32'h0000_0210);
    for (int i = 1; i <= 16; i++) load(PX, "pixel drain", 32'(i));
    load(PX, "pixel empty", 32'd0);
    load(ST, "status empty", 32'h0000_0100);

    // Push and pop together keep count steady
    for (int i = 0; i < 3; i++) op(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'(8'h21 + i));
    for (int i = 0; i < 5; i++) begin
      op(PX, 32'd0, 1'b0, 1'b1, 1'b1, 8'(8'h24 + i));
      lit_rd("pixel push+pop", 32'(8'h21 + i));
    end
    load(ST, "status three", 32'h0000_0003);
    for (int i = 0; i < 3; i++) load(PX, "pixel tail", 32'(8'h26 + i));

    // Fault handling
    store(32'h12, 32'h1234_5678);
    @(negedge clk);
    chk("fault misaligned", {31'b0, fault}, 32'd1);
    load(32'h10, "ram unchanged", 32'hDEADBEEF);
    store(32'h2000, 32'h0);
    @(negedge clk);
    chk("fault unmapped", {31'b0, fault}, 32'd1);
    load(ST, "status fault", 32'h8000_0100);
    store(ST, 32'h0);
    @(negedge clk);
    chk("fault cleared", {31'b0, fault}, 32'd0);

    // LED register
    store(LD, 32'h0000_00A5);
    @(negedge clk);
    chk("led a5", {24'b0, led}, 32'h0000_00A5);
    load(LD, "led read", 32'h0000_00A5);

    // Randomised traffic (RAM words 8..63 so word 4 keeps its value)
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(8, 63)) << 2;
        4:          a = ST;
        5, 6:       a = PX;
        7:          a = LD;
        8:          a = (32'($urandom_range(8, 63)) << 2) | 32'($urandom_range(1, 3));
        default:    a = 32'h2000 + (32'($urandom_range(0, 15)) << 2);
      endcase
      k = $urandom_range(0, 9);
      we = (k <= 2) || (k == 7);
      re = (k >= 3 && k <= 7);
      op(a, $urandom, we, re, 1'($urandom_range(0, 1)), 8'($urandom));
    end

    // Reset mid-stream
    store(ST, 32'h0);
    for (int i = 0; i < 20 && q.size() > 0; i++) op(PX, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 5; i++) op(32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
    store(LD, 32'h0000_00FF);
    load(ST, "status five", 32'h0000_0005);
    idle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset read_data", bus.read_data, 32'd0);
    chk("midreset led", {24'b0, led}, 32'd0);
    chk("midreset pix_ready", {31'b0, pix_ready}, 32'd1);
    chk("midreset fault", {31'b0, fault}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    load(ST, "status after reset", 32'h0000_0100);
    load(32'h10, "ram survives reset", 32'hDEADBEEF);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the processor's load/store port. Accepts the core's byte address, write data and write strobe. Serves a word RAM plus a small memory-mapped I/O window. The window includes a pixel FIFO filled by the camera capture path, so the core can pull pixels with ordinary loads.

## Interface
- DEPTH, 256: RAM size in 32-bit words (power of two).
- FIFO_DEPTH, 16: pixel FIFO entries (power of two, ≤ 64).
- MMIO_BASE, 32'h0000_1000: base byte address of the I/O window.

Ports:
- clk  in  1  single system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state below except RAM contents.
- address  in  32  byte address from the core (ALU result).
- write_data  in  32  store data.
- write_enable  in  1  store strobe.
- read_enable  in  1  load strobe.
- read_data  out  32  registered load data.
- pix_valid  in  1  camera pixel available.
- pix_data  in  8  camera pixel.
- pix_ready  out  1  FIFO can accept; equals !full.
- led  out  8  LED register.
- fault  out  1  sticky bad-access flag.

## Operation
- Address map, aligned words only (address[1:0] == 0):
  - RAM: 0 .. DEPTH*4-1, index address[log2(DEPTH)+1:2].
  - STATUS: MMIO_BASE+0. Read {fault, 21'b0, full, empty, 2'b0, count[5:0]}. Any write clears fault.
  - PIXEL: MMIO_BASE+4. Read returns {24'b0, head} and pops. Writes are ignored.
  - LED: MMIO_BASE+8. Write latches write_data[7:0]. Read returns {24'b0, led}.
- Bad access: misaligned or unmapped with write_enable or read_enable. Writes are dropped, read_data <= 0, and fault is set (sticky).
- write_enable and read_enable both high is a bad access. Nothing is written, no pop occurs, and fault is set.
- Loads: when read_enable is high, read_data updates at the next edge. When read_enable is low, read_data holds.
- RAM read-during-write to the same word: not possible on one port, because a store and a load are exclusive.
- FIFO push: occurs on pix_valid && pix_ready. Pop: occurs on a PIXEL read while count > 0.
- PIXEL read while empty: returns 0, no pop, fault is not set.
- Simultaneous push and pop: count is unchanged, and the popped value is the old head.
  - If empty, the push lands and the read returns 0.
  - If full, pix_ready = 0, so only the pop occurs.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH; full = (count == FIFO_DEPTH).

## Timing
- Reset values: read_data 0, led 0, fault 0, count 0, empty 1, full 0, pix_ready 1. Pointers are 0.
- Load latency is 1 cycle. Address and read_enable are sampled at edge N; read_data is valid after edge N and held until the next load.
- Store takes effect at the sampling edge. A load of the same address in the next cycle returns the new data.
- Register effects are visible to a load issued in the following cycle:
  - led changes at the edge after the store to LED.
  - fault sets at the edge of the bad access.
  - A STATUS write clears fault at its edge. If the same cycle is a bad access, set wins over clear.
- pix_ready is combinational from count. A pushed pixel is visible to a PIXEL read issued one cycle later.
- Asynchronous reset mid-operation:
  - Outputs go to their reset values immediately and the FIFO is emptied.
  - A store at the reset edge may or may not land in RAM; the bench must not check it.
  - pix_ready rises during reset.

## Test plan
- Store 32'hDEADBEEF to 0x10, then load 0x10 -> read_data = 32'hDEADBEEF one cycle after the load edge. Load of 0x14 (never written) is not checked.
- Push pixels 0x01..0x10 (16 pushes) -> pix_ready = 0 and STATUS reads 32'h0000_0210. A 17th pix_valid with 0x11 is not accepted. Sixteen PIXEL loads return 0x01..0x10 in order, then a PIXEL load returns 0 with empty = 1.
- With 3 entries, push while doing a PIXEL load each cycle for 5 cycles -> count stays 3 and data order is preserved.
- Store to 0x12 (misaligned) -> RAM is unchanged and fault = 1. Store to 0x2000 -> still 1. Store to STATUS -> fault = 0.
- Store 32'hA5 to LED -> led = 8'hA5 next cycle; load LED -> 32'h0000_00A5.
- Fill FIFO with 5 entries and set led = 8'hFF, then pulse reset low mid-stream -> count 0, led 0, read_data 0, pix_ready 1. RAM word 0x10 written before reset still reads back.
